adc_conv_sched: RTL and testbench
=================================

ADC_CONV_SCHED -- requirements
Module: adc_conv_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning the width of the ADC result.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the config fields and internal counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port en  input  1  run enable; low aborts the sequence and returns to idle.
REQ-006 SHALL have port samp_cycles  input  CNT_W  sample-phase length in cycles; 0 is treated as 1.
REQ-007 SHALL have port period_cycles  input  CNT_W  samp-rise to samp-rise interval in cycles.
REQ-008 SHALL have port timeout_cycles  input  CNT_W  maximum conversion cycles; 0 disables the timeout.
REQ-009 SHALL have port eoc  input  1  end-of-conversion from the SAR core; synchronous to clk.
REQ-010 SHALL have port adc_data  input  DATA_W  conversion result; valid while eoc=1.
REQ-011 SHALL have port samp  output  1  sample-switch control.
REQ-012 SHALL have port samp_b  output  1  complement of samp.
REQ-013 SHALL have port start  output  1  conversion start to the SAR core.
REQ-014 SHALL have port dout  output  DATA_W  last captured result.
REQ-015 SHALL have port dout_valid  output  1  one-cycle pulse when dout updates.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse when a conversion times out.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, SAMPLE, CONVERT and WAIT; all outputs SHALL be registered.
REQ-019 IDLE: samp=0, start=0; en=1 at an edge SHALL enter SAMPLE at that edge.
REQ-020 On SAMPLE entry, samp_cycles, period_cycles and timeout_cycles SHALL be latched; config changes mid-conversion SHALL have no effect until the next SAMPLE.
REQ-021 On SAMPLE entry, period_cnt SHALL clear to 0 and then increment every cycle, saturating at all-ones.
REQ-022 SAMPLE: samp=1, samp_b=0, start=0 for exactly max(samp_cycles,1) cycles, then enter CONVERT.
REQ-023 CONVERT: samp=0, samp_b=1, start=1; conv_cnt SHALL count cycles spent in CONVERT.
REQ-024 CONVERT, eoc=1 at an edge: dout<=adc_data, dout_valid=1 for one cycle, start=0, and enter WAIT.
REQ-025 CONVERT, timeout_cycles!=0, conv_cnt reaching timeout_cycles with eoc=0: timeout_err=1 for one cycle, start=0, dout unchanged, enter WAIT.
REQ-026 eoc and timeout at the same edge: eoc SHALL win; no timeout_err.
REQ-027 WAIT: samp=0, start=0.
REQ-028 WAIT SHALL go to SAMPLE when period_cnt+1>=period_cycles, eoc=0 and en=1.
REQ-029 When REQ-028 is met, samp SHALL rise exactly period_cycles cycles after the previous rise.
REQ-030 If period_cycles is shorter than the elapsed sample+convert time, WAIT SHALL last exactly 1 cycle.
REQ-031 WAIT SHALL hold while eoc=1, so no new sample starts until the core has dropped eoc.
REQ-032 en=0 at any edge in SAMPLE, CONVERT or WAIT: enter IDLE at that edge, samp=0, start=0; dout_valid is not asserted and dout is retained.
REQ-033 eoc in IDLE, SAMPLE or WAIT SHALL be ignored.
REQ-034 samp_b SHALL equal ~samp on every cycle, including during reset.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state=IDLE, samp=0, samp_b=1, start=0, dout=0, dout_valid=0, timeout_err=0, busy=0, and all counters to 0.
REQ-036 After rst_n deassertion with en=1, samp SHALL rise on the first clk edge.
REQ-037 Reset asserted mid-conversion SHALL discard the conversion with no dout_valid pulse.

Verification
REQ-038 Normal conversion: samp=3, period=20, eoc=1 on the 5th CONVERT cycle, adc_data=0x2A5 -> samp high 3 cycles, start high 5 cycles, dout=0x2A5, one dout_valid pulse, next samp rise 20 cycles after the first.
REQ-039 Timeout: timeout=6, eoc held 0 -> start high 6 cycles, one timeout_err pulse, dout unchanged, next sample still at period 20.
REQ-040 Overrun: period=4, samp=2, conversion 5 cycles -> WAIT lasts 1 cycle, next samp rise 8 cycles after the previous one.
REQ-041 Abort: en dropped during CONVERT -> IDLE next edge, start=0, no dout_valid; en reasserted -> samp rises on the next edge.
REQ-042 Boundaries: samp_cycles=0 gives a 1-cycle samp; eoc and timeout at the same edge gives dout_valid and no timeout_err; eoc held high in WAIT delays the next samp until eoc=0.
REQ-043 Async reset asserted between clock edges during SAMPLE -> outputs reach reset values immediately; samp_b=~samp is checked on every cycle.

Source files
------------

// File: rtl/adc_conv_sched.sv
// Sample/convert scheduler for a SAR ADC: drives the sample switch and conversion
// start on a fixed period, captures results on eoc and flags conversions that time out.
module adc_conv_sched #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  samp_cycles,
    input  logic [CNT_W-1:0]  period_cycles,
    input  logic [CNT_W-1:0]  timeout_cycles,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_data,
    output logic              samp,
    output logic              samp_b,
    output logic              start,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              timeout_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, WAIT} state_t;

    state_t state, state_d;

    logic [CNT_W-1:0]  samp_lat, period_lat, tmo_lat;
    logic [CNT_W-1:0]  samp_cnt, samp_cnt_d;
    logic [CNT_W-1:0]  conv_cnt, conv_cnt_d;
    logic [CNT_W-1:0]  period_cnt, period_cnt_d;
    logic [DATA_W-1:0] dout_d;
    logic              load_cfg, dout_valid_d, timeout_err_d;

    logic [CNT_W-1:0]  samp_eff;
    logic [CNT_W:0]    samp_cnt_inc, conv_cnt_inc, period_cnt_inc;
    logic              samp_done, tmo_hit, period_hit;

    // Increments are one bit wider so the comparisons never wrap at all-ones.
    assign samp_eff       = (samp_lat == '0) ? CNT_W'(1) : samp_lat;
    assign samp_cnt_inc   = {1'b0, samp_cnt} + 1'b1;
    assign conv_cnt_inc   = {1'b0, conv_cnt} + 1'b1;
    assign period_cnt_inc = {1'b0, period_cnt} + 1'b1;
    assign samp_done      = samp_cnt_inc >= {1'b0, samp_eff};
    assign tmo_hit        = (tmo_lat != '0) && (conv_cnt_inc >= {1'b0, tmo_lat});
    assign period_hit     = period_cnt_inc >= {1'b0, period_lat};

    always_comb begin
        state_d       = state;
        samp_cnt_d    = samp_cnt;
        conv_cnt_d    = conv_cnt;
        period_cnt_d  = period_cnt;
        dout_d        = dout;
        dout_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
        load_cfg      = 1'b0;

        if (state != IDLE && period_cnt != '1)
            period_cnt_d = period_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (en) begin
                    state_d      = SAMPLE;
                    load_cfg     = 1'b1;
                    samp_cnt_d   = '0;
                    period_cnt_d = '0;
                end
            end
            SAMPLE: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (samp_done) begin
                    state_d    = CONVERT;
                    conv_cnt_d = '0;
                end else begin
                    samp_cnt_d = samp_cnt + 1'b1;
                end
            end
            CONVERT: begin
                // A result arriving on the timeout edge still counts as a good conversion.
                if (!en) begin
                    state_d = IDLE;
                end else if (eoc) begin
                    state_d      = WAIT;
                    dout_d       = adc_data;
                    dout_valid_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d       = WAIT;
                    timeout_err_d = 1'b1;
                end else if (conv_cnt != '1) begin
                    conv_cnt_d = conv_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (period_hit && !eoc) begin
                    state_d      = SAMPLE;
                    load_cfg     = 1'b1;
                    samp_cnt_d   = '0;
                    period_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            samp_lat    <= '0;
            period_lat  <= '0;
            tmo_lat     <= '0;
            samp_cnt    <= '0;
            conv_cnt    <= '0;
            period_cnt  <= '0;
            samp        <= 1'b0;
            samp_b      <= 1'b1;
            start       <= 1'b0;
            busy        <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_d;
            samp_cnt   <= samp_cnt_d;
            conv_cnt   <= conv_cnt_d;
            period_cnt <= period_cnt_d;
            if (load_cfg) begin
                samp_lat   <= samp_cycles;
                period_lat <= period_cycles;
                tmo_lat    <= timeout_cycles;
            end
            samp        <= (state_d == SAMPLE);
            samp_b      <= (state_d != SAMPLE);
            start       <= (state_d == CONVERT);
            busy        <= (state_d != IDLE);
            dout        <= dout_d;
            dout_valid  <= dout_valid_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_adc_conv_sched.sv
// Bench for adc_conv_sched: a SAR-core stand-in answers start pulses, and expected
// timing is derived from frame arithmetic (sample length, conversion length, period).
module tb_adc_conv_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [7:0] samp_cycles = '0, period_cycles = '0, timeout_cycles = '0;
    logic       eoc = 1'b0;
    logic [9:0] adc_data = '0;
    logic       samp, samp_b, start, dout_valid, timeout_err, busy;
    logic [9:0] dout;

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_dout = '0;

    adc_conv_sched #(.DATA_W(10), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .samp_cycles(samp_cycles), .period_cycles(period_cycles),
        .timeout_cycles(timeout_cycles), .eoc(eoc), .adc_data(adc_data),
        .samp(samp), .samp_b(samp_b), .start(start), .dout(dout),
        .dout_valid(dout_valid), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (samp_b !== ~samp) begin
            failures++;
            $display("FAIL samp_b_compl t=%0t samp=%b samp_b=%b", $time, samp, samp_b);
        end
    end

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({samp, samp_b, start, dout_valid, timeout_err, busy} !== 6'b010000 || dout !== 10'd0) begin
            failures++;
            $display("FAIL reset_state got samp=%b samp_b=%b start=%b dv=%b te=%b busy=%b dout=%h",
                     samp, samp_b, start, dout_valid, timeout_err, busy, dout);
        end
        rst_n = 1'b1;
        exp_dout = '0;
    endtask

    // Runs nframes complete frames from IDLE and checks every cycle against frame arithmetic.
    task automatic run_seq(input string name, input int s, input int p, input int t,
                           input int clen, input int hold, input int fix_data, input int nframes);
        int   seff, conv, interval, budget, rises, last_rise;
        int   samp_run, start_run, hold_left;
        logic prev_samp, prev_start, exp_dv, exp_te, eoc_path;
        seff     = (s == 0) ? 1 : s;
        eoc_path = (clen != 0) && (t == 0 || clen <= t);
        conv     = eoc_path ? clen : t;
        interval = seff + conv + 1 + (eoc_path ? hold : 0);
        if (p > interval) interval = p;
        budget   = (nframes + 1) * interval + 20;
        @(negedge clk);
        samp_cycles = 8'(s); period_cycles = 8'(p); timeout_cycles = 8'(t);
        eoc = 1'b0; en = 1'b1;
        rises = 0; last_rise = -1; samp_run = 0; start_run = 0; hold_left = 0;
        prev_samp = 1'b0; prev_start = 1'b0; exp_dv = 1'b0; exp_te = 1'b0;
        for (int c = 0; c < budget && rises <= nframes; c++) begin
            @(negedge clk);
            checks++;
            if (dout_valid !== exp_dv) begin
                failures++;
                $display("FAIL %s dout_valid c=%0d got=%b exp=%b", name, c, dout_valid, exp_dv);
            end
            checks++;
            if (timeout_err !== exp_te) begin
                failures++;
                $display("FAIL %s timeout_err c=%0d got=%b exp=%b", name, c, timeout_err, exp_te);
            end
            checks++;
            if (dout !== exp_dout || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s dout_busy c=%0d dout=%h exp=%h busy=%b", name, c, dout, exp_dout, busy);
            end
            exp_dv = 1'b0;
            exp_te = 1'b0;
            if (samp && !prev_samp) begin
                checks++;
                if ((rises == 0 && c != 0) || (rises != 0 && c - last_rise != interval)) begin
                    failures++;
                    $display("FAIL %s samp_rise c=%0d interval=%0d exp=%0d", name, c, c - last_rise, interval);
                end
                last_rise = c;
                rises++;
            end
            if (!samp && prev_samp) begin
                checks++;
                if (samp_run != seff) begin
                    failures++;
                    $display("FAIL %s samp_len got=%0d exp=%0d", name, samp_run, seff);
                end
            end
            if (!start && prev_start) begin
                checks++;
                if (start_run != conv) begin
                    failures++;
                    $display("FAIL %s start_len got=%0d exp=%0d", name, start_run, conv);
                end
            end
            samp_run   = samp ? samp_run + 1 : 0;
            start_run  = start ? start_run + 1 : 0;
            prev_samp  = samp;
            prev_start = start;
            adc_data   = 10'($urandom);
            if (start) begin
                samp_cycles    = 8'($urandom);
                period_cycles  = 8'($urandom);
                timeout_cycles = 8'($urandom);
            end else begin
                samp_cycles = 8'(s); period_cycles = 8'(p); timeout_cycles = 8'(t);
            end
            if (start && clen != 0 && start_run == clen) begin
                eoc = 1'b1;
                hold_left = hold;
                if (fix_data >= 0) adc_data = 10'(fix_data);
                exp_dout = adc_data;
                exp_dv = 1'b1;
            end else if (hold_left > 0) begin
                eoc = 1'b1;
                hold_left--;
            end else if (samp && $urandom_range(0, 1) == 1) begin
                eoc = 1'b1;
            end else begin
                eoc = 1'b0;
            end
            if (start && t != 0 && start_run == t && !exp_dv) exp_te = 1'b1;
        end
        checks++;
        if (rises <= nframes) begin
            failures++;
            $display("FAIL %s frame_budget rises=%0d exp=%0d", name, rises, nframes + 1);
        end
        samp_cycles = 8'(s); period_cycles = 8'(p); timeout_cycles = 8'(t);
        en = 1'b0; eoc = 1'b0;
        @(negedge clk);
        checks++;
        if (samp !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || dout !== exp_dout) begin
            failures++;
            $display("FAIL %s disable samp=%b start=%b busy=%b dout=%h", name, samp, start, busy, dout);
        end
    endtask

    task automatic test_abort();
        int n;
        @(negedge clk);
        samp_cycles = 8'd2; period_cycles = 8'd30; timeout_cycles = 8'd0; en = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (start) n++;
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL abort_reach_convert start_cycles=%0d exp=2", n);
        end
        en = 1'b0; eoc = 1'b1; adc_data = 10'h155;
        @(negedge clk);
        checks++;
        if (start !== 1'b0 || samp !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0 || dout !== exp_dout) begin
            failures++;
            $display("FAIL abort_idle start=%b samp=%b busy=%b dv=%b dout=%h exp=%h",
                     start, samp, busy, dout_valid, dout, exp_dout);
        end
        eoc = 1'b0; en = 1'b1;
        @(negedge clk);
        checks++;
        if (samp !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart samp=%b exp=1", samp);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        samp_cycles = 8'd4; period_cycles = 8'd20; timeout_cycles = 8'd0; en = 1'b1;
        @(negedge clk);
        checks++;
        if (samp !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre samp=%b exp=1", samp);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_dout = '0;
        checks++;
        if ({samp, samp_b, start, dout_valid, timeout_err, busy} !== 6'b010000 || dout !== 10'd0) begin
            failures++;
            $display("FAIL areset_immediate samp=%b samp_b=%b start=%b dv=%b te=%b busy=%b dout=%h",
                     samp, samp_b, start, dout_valid, timeout_err, busy, dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (samp !== 1'b1) begin
            failures++;
            $display("FAIL areset_first_edge samp=%b exp=1", samp);
        end
        // Reset during a conversion whose result is arriving must drop it.
        n = 0;
        for (int c = 0; c < 20 && !start; c++) @(negedge clk);
        eoc = 1'b1; adc_data = 10'h3C3; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; eoc = 1'b0; en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || dout !== 10'd0) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL areset_mid_convert bad_cycles=%0d dout=%h exp=000", n, dout);
        end
    endtask

    task automatic test_random();
        int s, p, t, clen, hold;
        for (int i = 0; i < 6; i++) begin
            s    = $urandom_range(0, 6);
            p    = $urandom_range(0, 30);
            t    = $urandom_range(0, 10);
            clen = $urandom_range(0, 8);
            hold = $urandom_range(0, 3);
            if (clen == 0 && t == 0) t = 4;
            run_seq("random", s, p, t, clen, hold, -1, 2);
        end
    endtask

    initial begin
        test_reset();
        run_seq("normal", 3, 20, 0, 5, 0, 10'h2A5, 2);
        run_seq("timeout", 3, 20, 6, 0, 0, -1, 2);
        run_seq("overrun", 2, 4, 0, 5, 0, -1, 3);
        run_seq("samp_zero", 0, 10, 0, 3, 0, -1, 2);
        run_seq("eoc_tmo_tie", 2, 15, 5, 5, 0, -1, 2);
        run_seq("eoc_hold", 2, 8, 0, 3, 6, -1, 2);
        test_abort();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
